// File: rtl/ext_pkg.sv
// Shared definitions for the extension unit: operation encodings and lane sizing.
package ext_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_SEXT  = 3'b000;
  localparam mode_t MODE_ZEXT  = 3'b001;
  localparam mode_t MODE_UPPER = 3'b010;
  localparam mode_t MODE_WORD  = 3'b011;
  localparam mode_t MODE_LB    = 3'b100;
  localparam mode_t MODE_LBU   = 3'b101;
  localparam mode_t MODE_LH    = 3'b110;
  localparam mode_t MODE_LHU   = 3'b111;

  function automatic int lane_w(int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_unit_if.sv
// Request/result bundle between a producer stage and the extension unit.
interface ext_unit_if
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) ();
  localparam int LANE_W = lane_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  mode_t             in_mode;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] in_data;
  logic [LANE_W-1:0] in_lane;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_mode, in_imm, in_data, in_lane, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_data, in_lane, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_err, out_tag
  );
endinterface

// File: rtl/ext_core.sv
// Combinational immediate/load-lane extender; shared by decode and the writeback path.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int BIG_ENDIAN = 0,
  localparam int LANE_W    = lane_w(DATA_W)
) (
  input  mode_t             mode,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [LANE_W-1:0] lane,
  output logic [DATA_W-1:0] res,
  output logic              err
);
  localparam int NB = DATA_W / 8;
  localparam int UW = (IMM_W > 32) ? 32 : IMM_W;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("ext_core: DATA_W must be 32 or 64");
  end
  if (IMM_W > DATA_W || IMM_W < 1) begin : g_bad_imm_w
    $error("ext_core: IMM_W must be in 1..DATA_W");
  end
  if (DATA_W == 64 && IMM_W > 32) begin : g_bad_upper
    $error("ext_core: UPPER needs IMM_W <= 32 on a 64-bit datapath");
  end

  int          byte_sh;
  int          half_sh;
  int          half_lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] up32;

  // UPPER always builds a 32-bit LUI word; on 64-bit it is then sign-extended like MIPS64.
  always_comb begin
    half_lane = int'({lane[LANE_W-1:1], 1'b0});
    byte_sh   = (BIG_ENDIAN != 0) ? 8 * (NB - 1 - int'(lane)) : 8 * int'(lane);
    half_sh   = (BIG_ENDIAN != 0) ? 8 * (NB - 2 - half_lane) : 8 * half_lane;
    byte_v    = 8'(data >> byte_sh);
    half_v    = 16'(data >> half_sh);
    up32      = 32'(imm[UW-1:0]) << (32 - UW);
    res       = '0;
    err       = 1'b0;
    case (mode)
      MODE_SEXT:  res = DATA_W'($signed(imm));
      MODE_ZEXT:  res = DATA_W'(imm);
      MODE_UPPER: res = DATA_W'($signed(up32));
      MODE_WORD:  res = data;
      MODE_LB:    res = DATA_W'($signed(byte_v));
      MODE_LBU:   res = DATA_W'(byte_v);
      MODE_LH, MODE_LHU: begin
        if (lane[0]) begin
          err = 1'b1;
        end else if (mode == MODE_LH) begin
          res = DATA_W'($signed(half_v));
        end else begin
          res = DATA_W'(half_v);
        end
      end
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/ext_unit.sv
// Registered extension unit: ext_core result behind an output register plus one skid entry.
module ext_unit
  import ext_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int TAG_W      = 5,
  parameter int BIG_ENDIAN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  ext_unit_if.slave  bus
);
  logic [DATA_W-1:0] core_data;
  logic              core_err;

  ext_core #(
    .DATA_W     (DATA_W),
    .IMM_W      (IMM_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_core (
    .mode (bus.in_mode),
    .imm  (bus.in_imm),
    .data (bus.in_data),
    .lane (bus.in_lane),
    .res  (core_data),
    .err  (core_err)
  );

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_err_q,   out_err_d;
  logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              skid_err_q,   skid_err_d;
  logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;
  logic              in_ready_q,   in_ready_d;
  logic              accept;
  logic              out_free;

  // A waiting skid entry always goes to OUT before any new input, preserving order.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_tag_d   = skid_tag_q;
    accept       = bus.in_valid & in_ready_q;
    out_free     = !out_valid_q | bus.out_ready;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_data_d = core_data;
          skid_err_d  = core_err;
          skid_tag_d  = bus.in_tag;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = core_data;
          out_err_d  = core_err;
          out_tag_d  = bus.in_tag;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = core_data;
      skid_err_d   = core_err;
      skid_tag_d   = bus.in_tag;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_ext_unit.sv
// Directed scoreboard bench for ext_unit: little-endian main instance plus a big-endian one.
module tb_ext_unit;
  import ext_pkg::*;

  logic clk;
  logic rst_n;

  ext_unit_if #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) bus ();
  ext_unit_if #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) bus_be ();

  ext_unit #(.DATA_W(32), .IMM_W(16), .TAG_W(5), .BIG_ENDIAN(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ext_unit #(.DATA_W(32), .IMM_W(16), .TAG_W(5), .BIG_ENDIAN(1)) u_dut_be (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_be)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input mode_t mode, input logic [15:0] imm, input logic [31:0] data,
                               input logic [1:0] lane, input logic [4:0] tag,
                               input logic [31:0] exp_data, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_imm   = imm;
    bus.in_data  = data;
    bus.in_lane  = lane;
    bus.in_tag   = tag;
    pend.data    = exp_data;
    pend.err     = exp_err;
    pend.tag     = tag;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", bus.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_err", bus.out_err, e.err);
        chk("out_tag", bus.out_tag, e.tag);
      end
    end
  endtask

  // Called at a negedge: settles what the coming posedge will transfer, then advances.
  task automatic step_cycle();
    checkOutput();
    if (bus.in_valid && bus.in_ready) sb.push_back(pend);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 16 && sb.size() != 0; n++) step_cycle();
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic be_load(input mode_t mode, input logic [1:0] lane, input logic [31:0] exp_data,
                         input string name);
    chk({name, "_ready"}, bus_be.in_ready, 1'b1);
    bus_be.in_valid = 1'b1;
    bus_be.in_mode  = mode;
    bus_be.in_data  = 32'h1122_8344;
    if (mode == MODE_LH) bus_be.in_data = 32'h8000_F00D;
    bus_be.in_lane  = lane;
    @(negedge clk);
    bus_be.in_valid = 1'b0;
    chk({name, "_valid"}, bus_be.out_valid, 1'b1);
    chk({name, "_data"}, bus_be.out_data, exp_data);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_mode      = MODE_WORD;
    bus.in_imm       = '0;
    bus.in_data      = 32'hDEAD_BEEF;
    bus.in_lane      = '0;
    bus.in_tag       = 5'd31;
    bus.out_ready    = 1'b1;
    bus_be.in_valid  = 1'b0;
    bus_be.in_mode   = MODE_WORD;
    bus_be.in_imm    = '0;
    bus_be.in_data   = '0;
    bus_be.in_lane   = '0;
    bus_be.in_tag    = '0;
    bus_be.out_ready = 1'b1;
    pend             = '{data: 32'h0, err: 1'b0, tag: 5'd0};
    repeat (2) @(negedge clk);

    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_out_tag", bus.out_tag, 5'd0);
    chk("rst_in_ready", bus.in_ready, 1'b0);

    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    chk("post_rst_out_valid", bus.out_valid, 1'b0);

    $display("[TB] immediate and load modes");
    applyStimulus(MODE_SEXT, 16'h8001, 32'h0, 2'd0, 5'd1, 32'hFFFF_8001, 1'b0);
    step_cycle();
    chk("latency_sext", bus.out_valid, 1'b1);
    applyStimulus(MODE_ZEXT, 16'h8001, 32'h0, 2'd0, 5'd2, 32'h0000_8001, 1'b0);
    step_cycle();
    chk("latency_zext", bus.out_valid, 1'b1);
    applyStimulus(MODE_UPPER, 16'h1234, 32'h0, 2'd0, 5'd3, 32'h1234_0000, 1'b0);
    step_cycle();
    applyStimulus(MODE_LB, 16'h0, 32'h1122_8344, 2'd1, 5'd4, 32'hFFFF_FF83, 1'b0);
    step_cycle();
    applyStimulus(MODE_LBU, 16'h0, 32'h1122_8344, 2'd1, 5'd5, 32'h0000_0083, 1'b0);
    step_cycle();
    applyStimulus(MODE_LH, 16'h0, 32'h8000_F00D, 2'd2, 5'd6, 32'hFFFF_8000, 1'b0);
    step_cycle();
    applyStimulus(MODE_LHU, 16'h0, 32'h8000_F00D, 2'd0, 5'd7, 32'h0000_F00D, 1'b0);
    step_cycle();
    applyStimulus(MODE_LH, 16'h0, 32'h8000_F00D, 2'd1, 5'd8, 32'h0000_0000, 1'b1);
    step_cycle();
    applyStimulus(MODE_WORD, 16'h0, 32'hCAFE_0123, 2'd3, 5'd9, 32'hCAFE_0123, 1'b0);
    step_cycle();
    idle();
    wait_drain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(MODE_WORD, 16'h0, 32'hA1A1_A1A1, 2'd0, 5'd1, 32'hA1A1_A1A1, 1'b0);
    step_cycle();
    chk("bp_ready_before_2", bus.in_ready, 1'b1);
    applyStimulus(MODE_WORD, 16'h0, 32'hB2B2_B2B2, 2'd0, 5'd2, 32'hB2B2_B2B2, 1'b0);
    step_cycle();
    chk("bp_ready_after_2", bus.in_ready, 1'b0);
    applyStimulus(MODE_WORD, 16'h0, 32'hC3C3_C3C3, 2'd0, 5'd3, 32'hC3C3_C3C3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_valid", bus.out_valid, 1'b1);
      chk("bp_stall_tag", bus.out_tag, 5'd1);
      chk("bp_stall_data", bus.out_data, 32'hA1A1_A1A1);
      chk("bp_stall_ready", bus.in_ready, 1'b0);
      step_cycle();
    end
    bus.out_ready = 1'b1;
    step_cycle();
    chk("bp_consec2", bus.out_valid, 1'b1);
    step_cycle();
    idle();
    chk("bp_consec3", bus.out_valid, 1'b1);
    wait_drain();

    $display("[TB] reset with OUT and SKID full");
    bus.out_ready = 1'b0;
    applyStimulus(MODE_WORD, 16'h0, 32'h7777_7777, 2'd0, 5'd7, 32'h7777_7777, 1'b0);
    step_cycle();
    applyStimulus(MODE_WORD, 16'h0, 32'h8888_8888, 2'd0, 5'd8, 32'h8888_8888, 1'b0);
    step_cycle();
    idle();
    chk("mid_full_ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_data", bus.out_data, 32'h0);
    chk("mid_rst_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_stale", bus.out_valid, 1'b0);
      step_cycle();
    end

    $display("[TB] full rate");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(MODE_WORD, 16'h0, 32'h0101_0101 * (i + 1), 2'd0, 5'(16 + i),
                    32'h0101_0101 * (i + 1), 1'b0);
      chk("fr_ready", bus.in_ready, 1'b1);
      if (i > 0) chk("fr_valid", bus.out_valid, 1'b1);
      step_cycle();
    end
    idle();
    chk("fr_valid_last", bus.out_valid, 1'b1);
    wait_drain();
    chk("fr_empty", bus.out_valid, 1'b0);

    $display("[TB] big-endian lanes");
    be_load(MODE_LB, 2'd1, 32'h0000_0022, "be_lb1");
    be_load(MODE_LH, 2'd0, 32'hFFFF_8000, "be_lh0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
